// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler
// Brief    : Collapsing age-ordered reservation queue issuing to 2 ALU + 1 MEM
//            slot. Optional macro ISSUE_SCHED_WAKE_BYPASS_EN lets same-cycle
//            wakes count toward selection.
// Revision : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 96
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_alloc_valid,
    output logic                         o_alloc_ready,
    input  logic                         i_alloc_fu,
    input  logic [TAG_W-1:0]             i_alloc_src0_tag,
    input  logic [TAG_W-1:0]             i_alloc_src1_tag,
    input  logic                         i_alloc_src0_rdy,
    input  logic                         i_alloc_src1_rdy,
    input  logic [TAG_W-1:0]             i_alloc_dst,
    input  logic [PAYLOAD_W-1:0]         i_alloc_payload,
    input  logic [2:0]                   i_wake_valid,
    input  logic [3*TAG_W-1:0]           i_wake_tag,
    input  logic [2:0]                   i_fu_ready,
    output logic [2:0]                   o_issue_valid,
    output logic [3*TAG_W-1:0]           o_issue_dst,
    output logic [3*PAYLOAD_W-1:0]       o_issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     q_valid, q_fu, q_r0, q_r1;
    logic [TAG_W-1:0]     q_t0  [DEPTH];
    logic [TAG_W-1:0]     q_t1  [DEPTH];
    logic [TAG_W-1:0]     q_dst [DEPTH];
    logic [PAYLOAD_W-1:0] q_pay [DEPTH];

    logic [DEPTH-1:0]     n_valid, n_fu, n_r0, n_r1;
    logic [TAG_W-1:0]     n_t0  [DEPTH];
    logic [TAG_W-1:0]     n_t1  [DEPTH];
    logic [TAG_W-1:0]     n_dst [DEPTH];
    logic [PAYLOAD_W-1:0] n_pay [DEPTH];
    logic [CW-1:0]        n_count;

    logic [CW-1:0]        count;
    logic [2:0]           slot_valid;
    logic [TAG_W-1:0]     slot_dst [3];
    logic [PAYLOAD_W-1:0] slot_pay [3];

    logic [DEPTH-1:0]     wake0, wake1, elig, elig_alu, elig_mem, removed;
    logic [2:0]           loadable, sel_valid;
    logic [IW-1:0]        sel_idx [3];
    logic [IW-1:0]        a0, a1, m0;
    logic                 found_a0, found_a1, found_m;
    logic                 accept, alloc_w0, alloc_w1;

    function automatic logic woken(input logic [TAG_W-1:0] tag,
                                   input logic [2:0] wv,
                                   input logic [3*TAG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 3; j++)
            if (wv[j] && (wt[j*TAG_W +: TAG_W] == tag))
                hit = 1'b1;
        return hit;
    endfunction

    assign o_count       = count;
    assign o_alloc_ready = (count < CW'(DEPTH));
    assign o_issue_valid = slot_valid;
    assign accept        = i_alloc_valid && o_alloc_ready;
    assign alloc_w0      = woken(i_alloc_src0_tag, i_wake_valid, i_wake_tag);
    assign alloc_w1      = woken(i_alloc_src1_tag, i_wake_valid, i_wake_tag);

    always_comb begin
        wake0 = '0;
        wake1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake0[i] = woken(q_t0[i], i_wake_valid, i_wake_tag);
            wake1[i] = woken(q_t1[i], i_wake_valid, i_wake_tag);
        end
`ifdef ISSUE_SCHED_WAKE_BYPASS_EN
        elig = q_valid & (q_r0 | wake0) & (q_r1 | wake1);
`else
        elig = q_valid & q_r0 & q_r1;
`endif
        elig_alu = elig & ~q_fu;
        elig_mem = elig & q_fu;
    end

    // Oldest-first pick; FU1 falls back to the oldest ALU entry when FU0 is stalled.
    always_comb begin
        loadable = ~slot_valid | i_fu_ready;
        found_a0 = 1'b0;
        found_a1 = 1'b0;
        found_m  = 1'b0;
        a0 = '0;
        a1 = '0;
        m0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig_alu[i]) begin
                if (!found_a0) begin
                    found_a0 = 1'b1;
                    a0 = IW'(i);
                end else if (!found_a1) begin
                    found_a1 = 1'b1;
                    a1 = IW'(i);
                end
            end
            if (elig_mem[i] && !found_m) begin
                found_m = 1'b1;
                m0 = IW'(i);
            end
        end
        sel_valid[0] = loadable[0] && found_a0;
        sel_idx[0]   = a0;
        if (loadable[0]) begin
            sel_valid[1] = loadable[1] && found_a1;
            sel_idx[1]   = a1;
        end else begin
            sel_valid[1] = loadable[1] && found_a0;
            sel_idx[1]   = a0;
        end
        sel_valid[2] = loadable[2] && found_m;
        sel_idx[2]   = m0;
        removed = '0;
        for (int k = 0; k < 3; k++)
            if (sel_valid[k])
                removed[sel_idx[k]] = 1'b1;
    end

    always_comb begin
        int wp;
        n_valid = '0;
        n_fu    = '0;
        n_r0    = '0;
        n_r1    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_t0[i]  = '0;
            n_t1[i]  = '0;
            n_dst[i] = '0;
            n_pay[i] = '0;
        end
        wp = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && !removed[i]) begin
                n_valid[wp] = 1'b1;
                n_fu[wp]    = q_fu[i];
                n_r0[wp]    = q_r0[i] | wake0[i];
                n_r1[wp]    = q_r1[i] | wake1[i];
                n_t0[wp]    = q_t0[i];
                n_t1[wp]    = q_t1[i];
                n_dst[wp]   = q_dst[i];
                n_pay[wp]   = q_pay[i];
                wp = wp + 1;
            end
        end
        // count < DEPTH guarantees the append position is in range.
        if (accept) begin
            n_valid[wp] = 1'b1;
            n_fu[wp]    = i_alloc_fu;
            n_r0[wp]    = i_alloc_src0_rdy | alloc_w0;
            n_r1[wp]    = i_alloc_src1_rdy | alloc_w1;
            n_t0[wp]    = i_alloc_src0_tag;
            n_t1[wp]    = i_alloc_src1_tag;
            n_dst[wp]   = i_alloc_dst;
            n_pay[wp]   = i_alloc_payload;
            wp = wp + 1;
        end
        n_count = CW'(wp);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_valid <= '0;
            q_fu    <= '0;
            q_r0    <= '0;
            q_r1    <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_t0[i]  <= '0;
                q_t1[i]  <= '0;
                q_dst[i] <= '0;
                q_pay[i] <= '0;
            end
        end else if (i_flush) begin
            q_valid <= '0;
            count   <= '0;
        end else begin
            q_valid <= n_valid;
            q_fu    <= n_fu;
            q_r0    <= n_r0;
            q_r1    <= n_r1;
            count   <= n_count;
            for (int i = 0; i < DEPTH; i++) begin
                q_t0[i]  <= n_t0[i];
                q_t1[i]  <= n_t1[i];
                q_dst[i] <= n_dst[i];
                q_pay[i] <= n_pay[i];
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_slot
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                slot_valid[k] <= 1'b0;
                slot_dst[k]   <= '0;
                slot_pay[k]   <= '0;
            end else if (i_flush) begin
                slot_valid[k] <= 1'b0;
            end else if (sel_valid[k]) begin
                slot_valid[k] <= 1'b1;
                slot_dst[k]   <= q_dst[sel_idx[k]];
                slot_pay[k]   <= q_pay[sel_idx[k]];
            end else if (i_fu_ready[k]) begin
                slot_valid[k] <= 1'b0;
            end
        end
        assign o_issue_dst[k*TAG_W +: TAG_W]             = slot_dst[k];
        assign o_issue_payload[k*PAYLOAD_W +: PAYLOAD_W] = slot_pay[k];
    end

endmodule
`default_nettype wire
